// File: rtl/life_engine_rowscan.sv
// Game-of-Life evolution engine: ping-pong cell banks, one row of the next generation per clock.
// Programmable B/S rule, toroidal or dead-edge boundary, busy/done handshake and generation counter.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | host may clear/write cur_bank; step_req or run_en starts a step
//   S_CALC | row `row` of the next generation written into the other bank
//   S_SWAP | other bank becomes current, gen_count advances
module life_engine_rowscan #(
   parameter int ROW_W = 6,
   parameter int COL_W = 6,
   parameter int GEN_W = 16
) (
   input  logic             clk_envo,
   input  logic             rst,
   input  logic             write_en,
   input  logic [ROW_W-1:0] wAddrR,
   input  logic [COL_W-1:0] wAddrC,
   input  logic             write_data,
   input  logic [ROW_W-1:0] rAddrR,
   input  logic [COL_W-1:0] rAddrC,
   output logic             read_data,
   input  logic             clear,
   input  logic             step_req,
   input  logic             run_en,
   input  logic             wrap_mode,
   input  logic [8:0]       birth_mask,
   input  logic [8:0]       survive_mask,
   output logic             busy,
   output logic             step_done,
   output logic [GEN_W-1:0] gen_count
);

   localparam int ROWS = 2**ROW_W;
   localparam int COLS = 2**COL_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_SWAP = 2'd2;

   logic [ROWS-1:0][COLS-1:0] bank [2];
   logic                      cur_bank;
   logic [1:0]                state;
   logic [ROW_W-1:0]          row;
   logic [ROW_W-1:0]          row_prev;
   logic [ROW_W-1:0]          row_next;
   logic                      wrap_q;
   logic [8:0]                birth_q;
   logic [8:0]                survive_q;
   logic                      start;

   logic [COLS-1:0]  row_up;
   logic [COLS-1:0]  row_mid;
   logic [COLS-1:0]  row_dn;
   logic [COLS-1:0]  next_row;
   logic [COL_W-1:0] col_l;
   logic [COL_W-1:0] col_c;
   logic [COL_W-1:0] col_r;
   logic             has_l;
   logic             has_r;
   logic [7:0]       nb;
   logic [3:0]       n;

   assign start    = step_req | run_en;
   assign busy     = (state != S_IDLE);
   assign row_prev = row - ROW_W'(1);
   assign row_next = row + ROW_W'(1);

   // Neighbour rows outside the map read as dead unless the map wraps.
   always_comb begin
      row_mid = bank[cur_bank][row];
      row_up  = (wrap_q || (row != '0)) ? bank[cur_bank][row_prev] : '0;
      row_dn  = (wrap_q || (row != ROW_W'(ROWS-1))) ? bank[cur_bank][row_next] : '0;
   end

   always_comb begin
      next_row = '0;
      col_l    = '0;
      col_c    = '0;
      col_r    = '0;
      has_l    = 1'b0;
      has_r    = 1'b0;
      nb       = '0;
      n        = '0;
      for (int c = 0; c < COLS; c++) begin
         col_l = COL_W'(c - 1);
         col_c = COL_W'(c);
         col_r = COL_W'(c + 1);
         has_l = wrap_q || (c != 0);
         has_r = wrap_q || (c != COLS-1);
         nb = {row_up[col_c], row_dn[col_c],
               has_l & row_up[col_l], has_l & row_mid[col_l], has_l & row_dn[col_l],
               has_r & row_up[col_r], has_r & row_mid[col_r], has_r & row_dn[col_r]};
         n = '0;
         for (int k = 0; k < 8; k++) begin
            n = n + 4'(nb[k]);
         end
         next_row[c] = row_mid[col_c] ? survive_q[n] : birth_q[n];
      end
   end

   always_ff @(posedge clk_envo or posedge rst) begin
      if (rst) begin
         bank[0]   <= '0;
         bank[1]   <= '0;
         cur_bank  <= 1'b0;
         state     <= S_IDLE;
         row       <= '0;
         gen_count <= '0;
         step_done <= 1'b0;
         read_data <= 1'b0;
         wrap_q    <= 1'b0;
         birth_q   <= '0;
         survive_q <= '0;
      end else begin
         read_data <= bank[cur_bank][rAddrR][rAddrC];
         step_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (clear) begin
                  bank[cur_bank] <= '0;
                  gen_count      <= '0;
               end else if (write_en) begin
                  bank[cur_bank][wAddrR][wAddrC] <= write_data;
               end
               if (start) begin
                  wrap_q    <= wrap_mode;
                  birth_q   <= birth_mask;
                  survive_q <= survive_mask;
                  row       <= '0;
                  state     <= S_CALC;
               end
            end
            S_CALC: begin
               bank[~cur_bank][row] <= next_row;
               if (row == ROW_W'(ROWS-1)) begin
                  state <= S_SWAP;
               end else begin
                  row <= row_next;
               end
            end
            S_SWAP: begin
               cur_bank  <= ~cur_bank;
               gen_count <= gen_count + GEN_W'(1);
               step_done <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_life_engine_rowscan.sv
// Bench for life_engine_rowscan on a 16x16 map: table vectors, corner sequences and
// randomized maps/rules checked against a neighbour-counting reference model.
module tb_life_engine_rowscan;

   localparam int N = 16;
   localparam logic [3:0][7:0] BL_H = {8'h00, 8'h23, 8'h22, 8'h21};
   localparam logic [3:0][7:0] BL_V = {8'h00, 8'h32, 8'h22, 8'h12};

   logic        clk_envo = 1'b0;
   logic        rst = 1'b1;
   logic        write_en = 1'b0;
   logic [3:0]  wAddrR = '0;
   logic [3:0]  wAddrC = '0;
   logic        write_data = 1'b0;
   logic [3:0]  rAddrR = '0;
   logic [3:0]  rAddrC = '0;
   logic        read_data;
   logic        clear = 1'b0;
   logic        step_req = 1'b0;
   logic        run_en = 1'b0;
   logic        wrap_mode = 1'b0;
   logic [8:0]  birth_mask = 9'h008;
   logic [8:0]  survive_mask = 9'h00C;
   logic        busy;
   logic        step_done;
   logic [15:0] gen_count;

   life_engine_rowscan #(.ROW_W(4), .COL_W(4), .GEN_W(16)) dut (
      .clk_envo(clk_envo), .rst(rst), .write_en(write_en), .wAddrR(wAddrR), .wAddrC(wAddrC),
      .write_data(write_data), .rAddrR(rAddrR), .rAddrC(rAddrC), .read_data(read_data),
      .clear(clear), .step_req(step_req), .run_en(run_en), .wrap_mode(wrap_mode),
      .birth_mask(birth_mask), .survive_mask(survive_mask), .busy(busy),
      .step_done(step_done), .gen_count(gen_count)
   );

   always #5 clk_envo = ~clk_envo;

   typedef struct packed {
      logic            wrap;
      logic [8:0]      birth;
      logic [8:0]      survive;
      logic [2:0]      n_in;
      logic [3:0][7:0] cin;
      logic [2:0]      n_out;
      logic [3:0][7:0] cout;
   } vec_t;

   vec_t vt [5];
   int   vectors = 0;
   int   miscompares = 0;
   bit   mdl [N][N];
   bit   exp_map [N][N];
   bit   dut_map [N][N];

   task automatic check(string name, int act, int want);
      vectors++;
      if (act != want) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) mdl[r][c] = 1'b0;
   endtask

   // Next generation straight from the B/S rule: count the 8 surrounding cells.
   task automatic model_step(bit wrap, bit [8:0] b, bit [8:0] s);
      bit nx [N][N];
      int cnt, rr, cc;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr == 0 && dc == 0) continue;
                  rr = r + dr;
                  cc = c + dc;
                  if (wrap) begin
                     rr = (rr + N) % N;
                     cc = (cc + N) % N;
                  end else if (rr < 0 || rr >= N || cc < 0 || cc >= N) begin
                     continue;
                  end
                  cnt += int'(mdl[rr][cc]);
               end
            end
            nx[r][c] = mdl[r][c] ? s[cnt] : b[cnt];
         end
      end
      mdl = nx;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk_envo);
      clear = 1'b0;
   endtask

   task automatic write_cell(int r, int c, bit v);
      write_en   = 1'b1;
      wAddrR     = 4'(r);
      wAddrC     = 4'(c);
      write_data = v;
      @(negedge clk_envo);
      write_en   = 1'b0;
   endtask

   task automatic load_list(logic [3:0][7:0] cells, int cnt);
      for (int k = 0; k < cnt; k++) begin
         write_cell(int'(cells[k][7:4]), int'(cells[k][3:0]), 1'b1);
         mdl[cells[k][7:4]][cells[k][3:0]] = 1'b1;
      end
   endtask

   task automatic set_exp_zero();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) exp_map[r][c] = 1'b0;
   endtask

   task automatic set_exp(logic [3:0][7:0] cells, int cnt);
      set_exp_zero();
      for (int k = 0; k < cnt; k++) exp_map[cells[k][7:4]][cells[k][3:0]] = 1'b1;
   endtask

   task automatic check_map(string name);
      int diffs = 0;
      for (int i = 0; i < N*N; i++) begin
         rAddrR = 4'(i >> 4);
         rAddrC = 4'(i & 15);
         @(negedge clk_envo);
         dut_map[i >> 4][i & 15] = read_data;
      end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            if (dut_map[r][c] != exp_map[r][c]) diffs++;
      check({name, " map cells differing"}, diffs, 0);
   endtask

   task automatic wait_done(string name, int exp_busy);
      int cyc = 0;
      while (busy && cyc < 200) begin
         cyc++;
         @(negedge clk_envo);
      end
      check({name, " busy cycles"}, cyc, exp_busy);
      check({name, " step_done high"}, int'(step_done), 1);
      @(negedge clk_envo);
      check({name, " step_done width"}, int'(step_done), 0);
   endtask

   task automatic issue_step(string name);
      step_req = 1'b1;
      @(negedge clk_envo);
      step_req = 1'b0;
      wait_done(name, 17);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nd, cyc, steps;
      int t [4];

      vt[0] = '{wrap:1'b0, birth:9'h008, survive:9'h00C, n_in:3'd3, cin:BL_H, n_out:3'd3, cout:BL_V};
      vt[1] = '{wrap:1'b1, birth:9'h008, survive:9'h00C, n_in:3'd3, cin:{8'h00, 8'h01, 8'h00, 8'h0F},
                n_out:3'd3, cout:{8'h00, 8'h10, 8'h00, 8'hF0}};
      vt[2] = '{wrap:1'b0, birth:9'h008, survive:9'h00C, n_in:3'd3, cin:{8'h00, 8'h01, 8'h00, 8'h0F},
                n_out:3'd0, cout:'0};
      vt[3] = '{wrap:1'b0, birth:9'h004, survive:9'h000, n_in:3'd2, cin:{8'h00, 8'h00, 8'h56, 8'h55},
                n_out:3'd4, cout:{8'h66, 8'h65, 8'h46, 8'h45}};
      vt[4] = '{wrap:1'b0, birth:9'h008, survive:9'h00C, n_in:3'd4, cin:{8'hFF, 8'hFE, 8'hEF, 8'hEE},
                n_out:3'd4, cout:{8'hFF, 8'hFE, 8'hEF, 8'hEE}};

      // reset state
      repeat (2) @(negedge clk_envo);
      rst = 1'b0;
      @(negedge clk_envo);
      check("reset busy", int'(busy), 0);
      check("reset step_done", int'(step_done), 0);
      check("reset gen_count", int'(gen_count), 0);
      set_exp_zero();
      check_map("reset");

      // table vectors: one step each from a cleared map
      for (int v = 0; v < 5; v++) begin
         pulse_clear();
         model_clear();
         wrap_mode    = vt[v].wrap;
         birth_mask   = vt[v].birth;
         survive_mask = vt[v].survive;
         load_list(vt[v].cin, int'(vt[v].n_in));
         issue_step($sformatf("vec%0d", v));
         check($sformatf("vec%0d gen_count", v), int'(gen_count), 1);
         set_exp(vt[v].cout, int'(vt[v].n_out));
         check_map($sformatf("vec%0d", v));
      end
      wrap_mode = 1'b0; birth_mask = 9'h008; survive_mask = 9'h00C;

      // blinker two steps returns to the original row
      pulse_clear();
      load_list(BL_H, 3);
      issue_step("blinker1");
      issue_step("blinker2");
      check("blinker2 gen_count", int'(gen_count), 2);
      set_exp(BL_H, 3);
      check_map("blinker2");

      // reset in the middle of a step
      step_req = 1'b1;
      @(negedge clk_envo);
      step_req = 1'b0;
      repeat (10) @(negedge clk_envo);
      check("midcalc busy before rst", int'(busy), 1);
      #1 rst = 1'b1;
      #1;
      check("midcalc busy after rst", int'(busy), 0);
      check("midcalc gen_count", int'(gen_count), 0);
      @(negedge clk_envo);
      rst = 1'b0;
      @(negedge clk_envo);
      check("midcalc step_done", int'(step_done), 0);
      set_exp_zero();
      check_map("midcalc");

      // write and start on the same edge: the write is part of the step
      pulse_clear();
      write_cell(2, 1, 1'b1);
      write_cell(2, 3, 1'b1);
      write_en = 1'b1; wAddrR = 4'd2; wAddrC = 4'd2; write_data = 1'b1; step_req = 1'b1;
      @(negedge clk_envo);
      write_en = 1'b0; step_req = 1'b0;
      wait_done("write+start", 17);
      set_exp(BL_V, 3);
      check_map("write+start");

      // clear and start on the same edge: step runs on the cleared map
      clear = 1'b1; step_req = 1'b1;
      @(negedge clk_envo);
      clear = 1'b0; step_req = 1'b0;
      wait_done("clear+start", 17);
      check("clear+start gen_count", int'(gen_count), 1);
      set_exp_zero();
      check_map("clear+start");

      // host activity and rule changes while busy are ignored
      pulse_clear();
      load_list(BL_H, 3);
      step_req = 1'b1;
      @(negedge clk_envo);
      step_req = 1'b0;
      repeat (3) @(negedge clk_envo);
      write_en = 1'b1; wAddrR = 4'd8; wAddrC = 4'd8; write_data = 1'b1;
      step_req = 1'b1; clear = 1'b1; wrap_mode = 1'b1; birth_mask = 9'h1FF; survive_mask = 9'h000;
      @(negedge clk_envo);
      write_en = 1'b0; step_req = 1'b0; clear = 1'b0;
      wait_done("busy-ignore", 13);
      wrap_mode = 1'b0; birth_mask = 9'h008; survive_mask = 9'h00C;
      repeat (5) @(negedge clk_envo);
      check("busy-ignore idle busy", int'(busy), 0);
      check("busy-ignore gen_count", int'(gen_count), 1);
      set_exp(BL_V, 3);
      check_map("busy-ignore");

      // free-run: four back-to-back steps
      pulse_clear();
      load_list(BL_H, 3);
      run_en = 1'b1;
      nd = 0; cyc = 0;
      for (int k = 0; k < 4; k++) t[k] = 0;
      while (nd < 4 && cyc < 200) begin
         @(negedge clk_envo);
         cyc++;
         if (step_done) begin
            t[nd] = cyc;
            nd++;
            if (nd == 4) run_en = 1'b0;
         end
      end
      run_en = 1'b0;
      check("run_en done count", nd, 4);
      check("run_en first done", t[0], 18);
      for (int k = 1; k < 4; k++) check($sformatf("run_en interval%0d", k), t[k] - t[k-1], 18);
      repeat (3) @(negedge clk_envo);
      check("run_en stopped", int'(busy), 0);
      check("run_en gen_count", int'(gen_count), 4);
      set_exp(BL_H, 3);
      check_map("run_en");

      // random maps and rules against the reference model
      for (int it = 0; it < 12; it++) begin
         pulse_clear();
         model_clear();
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               if ($urandom_range(2) == 0) begin
                  write_cell(r, c, 1'b1);
                  mdl[r][c] = 1'b1;
               end
         wrap_mode = 1'($urandom_range(1));
         if ($urandom_range(1) == 0) begin
            birth_mask = 9'h008; survive_mask = 9'h00C;
         end else begin
            birth_mask = 9'($urandom); survive_mask = 9'($urandom);
         end
         steps = 1 + $urandom_range(1);
         for (int s = 0; s < steps; s++) begin
            issue_step($sformatf("rand%0d", it));
            model_step(wrap_mode, birth_mask, survive_mask);
         end
         check($sformatf("rand%0d gen_count", it), int'(gen_count), steps);
         exp_map = mdl;
         check_map($sformatf("rand%0d", it));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
